hv_timing_ctrl: RTL and testbench
=================================

Name: hv_timing_ctrl

Overview:
- Sequences the cascaded 9-bit horizontal/vertical counter chain behind the video timing: increment, carry-driven preload (wrap) and blank/sync flag generation.
- Replaces the hand-wired carry-to-load feedback around the binary counter stages.
- Exposes the chain's load strobes so downstream logic sees the same timing as the discrete board.
- Sits between the pixel-clock enable divider and the video/sprite address logic.

Parameters:
H_START, 9'd128, horizontal preload value; line length = 512 - H_START (default 384)
V_START, 9'd248, vertical preload value; frame length = 512 - V_START (default 264)
HBLANK_ON, 9'd144, hcnt value at which hblank asserts
HBLANK_OFF, 9'd272, hcnt value at which hblank deasserts
HSYNC_ON, 9'd176, hcnt value at which hsync_n asserts (low)
HSYNC_OFF, 9'd208, hcnt value at which hsync_n deasserts
VBLANK_ON, 9'd496, vcnt value at which vblank asserts
VBLANK_OFF, 9'd272, vcnt value at which vblank deasserts
VSYNC_ON, 9'd504, vcnt value at which vsync_n asserts
VSYNC_OFF, 9'd508, vcnt value at which vsync_n deasserts

Ports:
clk  in  1  system clock; all state on rising edge
clear_n  in  1  asynchronous active-low reset
pix_ce  in  1  pixel clock enable, one clk wide
run  in  1  count enable, equivalent to T and P tied together on the chain
hcnt  out  9  horizontal count
vcnt  out  9  vertical count
h_load_n  out  1  horizontal preload strobe, low on the wrap cycle
v_load_n  out  1  vertical preload strobe, low on the frame-wrap cycle
line_start  out  1  one-clk pulse on the edge hcnt becomes H_START via wrap
frame_start  out  1  one-clk pulse on the edge vcnt becomes V_START via wrap
hblank  out  1  horizontal blank flag
vblank  out  1  vertical blank flag
hsync_n  out  1  horizontal sync, active low
vsync_n  out  1  vertical sync, active low

Behaviour:
- Reset is asynchronous on clear_n low. Reset values: hcnt=H_START, vcnt=V_START, hblank=1, vblank=1, hsync_n=1, vsync_n=1, line_start=0, frame_start=0.
- Reset takes effect mid-line; no partial state survives.
- Advance condition: adv = pix_ce & run. When adv=0, all registers hold and line_start/frame_start are 0.
- Horizontal counter on adv:
  - hcnt==511: hcnt <= H_START (carry-driven load).
  - otherwise: hcnt <= hcnt+1.
- h_load_n is combinational: low exactly when run & hcnt==511, independent of pix_ce. This matches a ripple carry feeding load_n.
- Vertical counter advances only on adv & hcnt==511 (horizontal carry):
  - vcnt==511: vcnt <= V_START.
  - otherwise: vcnt <= vcnt+1.
- v_load_n is combinational: low when run & hcnt==511 & vcnt==511.
- line_start is registered: 1 for one clk after the edge where hcnt reloads.
- frame_start is registered: 1 for one clk after the edge where vcnt reloads. It coincides with line_start.
- Flags are set/clear flip-flops updated on adv, based on the next count value:
  - hblank <= 1 when next hcnt==HBLANK_ON; hblank <= 0 when next hcnt==HBLANK_OFF.
  - hsync_n follows the same rule with HSYNC_ON/HSYNC_OFF.
  - vblank/vsync_n use next vcnt and are updated only on the horizontal-carry edge.
  - Flags therefore change on the same edge as the counter. There is no extra latency.
- If ON==OFF for a flag pair, the OFF action wins and the flag is held inactive.
- ON/OFF values outside the count range [START..511] are never matched; the flag holds its reset value.
- Only 9-bit wraparound is used. No parameter value produces a count below START.
- When run drops mid-line, counts freeze. Resuming continues from the frozen count, with no skip or duplicate.

Test Plan:
- Reset: pulse clear_n low mid-count with pix_ce=1 -> hcnt=128 and vcnt=248 immediately (asynchronous); hblank=1, vblank=1, both syncs=1.
- Line wrap: run=1, pix_ce=1 every clk, start from reset, 384 clks -> hcnt walks 128..511. h_load_n is low only while hcnt=511. The next edge gives hcnt=128, line_start=1 for one clk, and vcnt=249.
- Pixel enable: pix_ce every 4th clk -> hcnt changes only on pix_ce edges; line period = 1536 clks; h_load_n is low for the 4 clks at hcnt=511.
- Frame wrap: run a full frame -> after 384*264=101376 pix_ce edges, vcnt=248 and hcnt=128. frame_start and line_start pulse together. v_load_n was low only at hcnt=511 & vcnt=511.
- Flag timing: hblank rises on the edge hcnt becomes 144 and falls at 272. hsync_n is low for hcnt 176..207. vblank rises at vcnt 496 and falls at 272 of the next frame. vsync_n is low for vcnt 504..507.
- Freeze: drop run at hcnt=300 for 50 clks -> hcnt stays 300 and h_load_n stays high. After run returns, hcnt=301 on the next pix_ce edge.

Source files
------------

// File: rtl/hv_timing_ctrl.sv
// Purpose : cascaded 9-bit horizontal/vertical video timing counters with
//           carry-driven preload, exposed load strobes and blank/sync flags.
// Latency : counts and flags update on the clk edge where pix_ce & run is
//           high; load strobes are combinational from the current count.
// Stall   : run low (or pix_ce low) freezes every register; no handshake.
//
// Ports:
//   clk, clear_n        clock and asynchronous active-low reset
//   pix_ce, run         pixel-clock enable and count enable (advance = both)
//   hcnt, vcnt          horizontal / vertical counts (H_START..511, V_START..511)
//   h_load_n, v_load_n  active-low preload strobes (ripple-carry style)
//   line_start          one-clk pulse after hcnt wraps to H_START
//   frame_start         one-clk pulse after vcnt wraps to V_START
//   hblank, vblank      blank flags (active high)
//   hsync_n, vsync_n    sync flags (active low)
module hv_timing_ctrl #(
  parameter logic [8:0] H_START    = 9'd128,
  parameter logic [8:0] V_START    = 9'd248,
  parameter logic [8:0] HBLANK_ON  = 9'd144,
  parameter logic [8:0] HBLANK_OFF = 9'd272,
  parameter logic [8:0] HSYNC_ON   = 9'd176,
  parameter logic [8:0] HSYNC_OFF  = 9'd208,
  parameter logic [8:0] VBLANK_ON  = 9'd496,
  parameter logic [8:0] VBLANK_OFF = 9'd272,
  parameter logic [8:0] VSYNC_ON   = 9'd504,
  parameter logic [8:0] VSYNC_OFF  = 9'd508
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       pix_ce,
  input  logic       run,
  output logic [8:0] hcnt,
  output logic [8:0] vcnt,
  output logic       h_load_n,
  output logic       v_load_n,
  output logic       line_start,
  output logic       frame_start,
  output logic       hblank,
  output logic       vblank,
  output logic       hsync_n,
  output logic       vsync_n
);

  logic [8:0] hcnt_q, hcnt_d;
  logic [8:0] vcnt_q, vcnt_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       hblank_q, hblank_d;
  logic       vblank_q, vblank_d;
  logic       hsync_n_q, hsync_n_d;
  logic       vsync_n_q, vsync_n_d;

  logic       adv;
  logic       h_carry;
  logic       v_at_max;
  logic [8:0] hcnt_nxt;
  logic [8:0] vcnt_nxt;

  // Set/clear flop next state; the clear (OFF) match has priority so an
  // ON==OFF pair keeps the flag inactive.
  function automatic logic flag_nxt(input logic cur, input logic on_hit,
                                    input logic off_hit, input logic act);
    if (off_hit) begin
      return ~act;
    end else if (on_hit) begin
      return act;
    end else begin
      return cur;
    end
  endfunction

  always_comb begin
    adv      = pix_ce & run;
    h_carry  = (hcnt_q == 9'h1FF);
    v_at_max = (vcnt_q == 9'h1FF);
    hcnt_nxt = h_carry  ? H_START : hcnt_q + 9'd1;
    vcnt_nxt = v_at_max ? V_START : vcnt_q + 9'd1;

    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    hblank_d      = hblank_q;
    hsync_n_d     = hsync_n_q;
    vblank_d      = vblank_q;
    vsync_n_d     = vsync_n_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (adv) begin
      hcnt_d    = hcnt_nxt;
      hblank_d  = flag_nxt(hblank_q, hcnt_nxt == HBLANK_ON,
                           hcnt_nxt == HBLANK_OFF, 1'b1);
      hsync_n_d = flag_nxt(hsync_n_q, hcnt_nxt == HSYNC_ON,
                           hcnt_nxt == HSYNC_OFF, 1'b0);
      // Vertical stage is enabled by the horizontal carry only.
      if (h_carry) begin
        vcnt_d        = vcnt_nxt;
        vblank_d      = flag_nxt(vblank_q, vcnt_nxt == VBLANK_ON,
                                 vcnt_nxt == VBLANK_OFF, 1'b1);
        vsync_n_d     = flag_nxt(vsync_n_q, vcnt_nxt == VSYNC_ON,
                                 vcnt_nxt == VSYNC_OFF, 1'b0);
        line_start_d  = 1'b1;
        frame_start_d = v_at_max;
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      hcnt_q        <= H_START;
      vcnt_q        <= V_START;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
    end
  end

  // Load strobes mirror the ripple carry: gated by run but not by pix_ce.
  assign h_load_n    = ~(run & h_carry);
  assign v_load_n    = ~(run & h_carry & v_at_max);
  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;

endmodule

// File: tb/tb_hv_timing_ctrl.sv
// Bench for hv_timing_ctrl: one default-parameter instance and one short-frame
// instance (ON==OFF and out-of-range flag settings), both compared every cycle
// against a position-based model, plus pinned literal expectations.
module tb_hv_timing_ctrl;

  typedef struct packed {
    logic [8:0] hst, vst, hbon, hboff, hson, hsoff, vbon, vboff, vson, vsoff;
  } prm_t;

  typedef struct {
    int p;                 // advances since reset, modulo frame length
    bit hb, vb, hsn, vsn;  // flag states
    bit ls, fs;            // registered start pulses
  } mst_t;

  localparam prm_t PA = '{hst: 9'd128, vst: 9'd248, hbon: 9'd144, hboff: 9'd272,
                          hson: 9'd176, hsoff: 9'd208, vbon: 9'd496, vboff: 9'd272,
                          vson: 9'd504, vsoff: 9'd508};
  localparam prm_t PB = '{hst: 9'd128, vst: 9'd488, hbon: 9'd100, hboff: 9'd272,
                          hson: 9'd200, hsoff: 9'd200, vbon: 9'd496, vboff: 9'd492,
                          vson: 9'd504, vsoff: 9'd508};

  logic clk = 1'b0;
  logic clear_n, pix_ce, run;
  int   pin = 0;
  int   tests = 0;
  int   fails = 0;

  logic [8:0] hcnt_a, vcnt_a, hcnt_b, vcnt_b;
  logic h_load_n_a, v_load_n_a, line_start_a, frame_start_a;
  logic hblank_a, vblank_a, hsync_n_a, vsync_n_a;
  logic h_load_n_b, v_load_n_b, line_start_b, frame_start_b;
  logic hblank_b, vblank_b, hsync_n_b, vsync_n_b;

  mst_t ma, mb;

  always #5 clk = ~clk;

  hv_timing_ctrl dut_a (
    .clk(clk), .clear_n(clear_n), .pix_ce(pix_ce), .run(run),
    .hcnt(hcnt_a), .vcnt(vcnt_a), .h_load_n(h_load_n_a), .v_load_n(v_load_n_a),
    .line_start(line_start_a), .frame_start(frame_start_a),
    .hblank(hblank_a), .vblank(vblank_a), .hsync_n(hsync_n_a), .vsync_n(vsync_n_a)
  );

  hv_timing_ctrl #(
    .H_START(PB.hst), .V_START(PB.vst), .HBLANK_ON(PB.hbon), .HBLANK_OFF(PB.hboff),
    .HSYNC_ON(PB.hson), .HSYNC_OFF(PB.hsoff), .VBLANK_ON(PB.vbon),
    .VBLANK_OFF(PB.vboff), .VSYNC_ON(PB.vson), .VSYNC_OFF(PB.vsoff)
  ) dut_b (
    .clk(clk), .clear_n(clear_n), .pix_ce(pix_ce), .run(run),
    .hcnt(hcnt_b), .vcnt(vcnt_b), .h_load_n(h_load_n_b), .v_load_n(v_load_n_b),
    .line_start(line_start_b), .frame_start(frame_start_b),
    .hblank(hblank_b), .vblank(vblank_b), .hsync_n(hsync_n_b), .vsync_n(vsync_n_b)
  );

  // ---------------- behavioural model ----------------
  function automatic mst_t m_reset();
    mst_t r;
    r.p = 0; r.hb = 1; r.vb = 1; r.hsn = 1; r.vsn = 1; r.ls = 0; r.fs = 0;
    return r;
  endfunction

  function automatic int m_h(prm_t c, mst_t s);
    return int'(c.hst) + s.p % (512 - int'(c.hst));
  endfunction

  function automatic int m_v(prm_t c, mst_t s);
    return int'(c.vst) + s.p / (512 - int'(c.hst));
  endfunction

  function automatic mst_t m_step(prm_t c, mst_t s, bit adv);
    mst_t r;
    int   len_l, len_f, h, v;
    bit   wh, wv;
    r = s;
    r.ls = 0;
    r.fs = 0;
    if (!adv) return r;
    len_l = 512 - int'(c.hst);
    len_f = 512 - int'(c.vst);
    wh = (s.p % len_l) == len_l - 1;
    wv = wh && ((s.p / len_l) == len_f - 1);
    r.p = (s.p + 1) % (len_l * len_f);
    h = m_h(c, r);
    v = m_v(c, r);
    if (h == int'(c.hboff)) r.hb = 0; else if (h == int'(c.hbon)) r.hb = 1;
    if (h == int'(c.hsoff)) r.hsn = 1; else if (h == int'(c.hson)) r.hsn = 0;
    if (wh) begin
      if (v == int'(c.vboff)) r.vb = 0; else if (v == int'(c.vbon)) r.vb = 1;
      if (v == int'(c.vsoff)) r.vsn = 1; else if (v == int'(c.vson)) r.vsn = 0;
    end
    r.ls = wh;
    r.fs = wv;
    return r;
  endfunction

  always @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      ma <= m_reset();
      mb <= m_reset();
    end else begin
      ma <= m_step(PA, ma, pix_ce && run);
      mb <= m_step(PB, mb, pix_ce && run);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_dut(input string t, input prm_t c, input mst_t s,
                         input logic [8:0] hc, input logic [8:0] vc,
                         input logic hl, input logic vl, input logic ls,
                         input logic fs, input logic hb, input logic vb,
                         input logic hs, input logic vs);
    int h, v;
    h = m_h(c, s);
    v = m_v(c, s);
    chk({t, "_hcnt"}, int'(hc), h);
    chk({t, "_vcnt"}, int'(vc), v);
    chk({t, "_h_load_n"}, int'(hl), (run && h == 511) ? 0 : 1);
    chk({t, "_v_load_n"}, int'(vl), (run && h == 511 && v == 511) ? 0 : 1);
    chk({t, "_line_start"}, int'(ls), int'(s.ls));
    chk({t, "_frame_start"}, int'(fs), int'(s.fs));
    chk({t, "_hblank"}, int'(hb), int'(s.hb));
    chk({t, "_vblank"}, int'(vb), int'(s.vb));
    chk({t, "_hsync_n"}, int'(hs), int'(s.hsn));
    chk({t, "_vsync_n"}, int'(vs), int'(s.vsn));
  endtask

  always @(negedge clk) begin
    chk_dut("a", PA, ma, hcnt_a, vcnt_a, h_load_n_a, v_load_n_a, line_start_a,
            frame_start_a, hblank_a, vblank_a, hsync_n_a, vsync_n_a);
    chk_dut("b", PB, mb, hcnt_b, vcnt_b, h_load_n_b, v_load_n_b, line_start_b,
            frame_start_b, hblank_b, vblank_b, hsync_n_b, vsync_n_b);
    case (pin)
      1: begin
        chk("rst_hcnt", int'(hcnt_a), 128);
        chk("rst_vcnt", int'(vcnt_a), 248);
        chk("rst_vcnt_b", int'(vcnt_b), 488);
        chk("rst_hblank", int'(hblank_a), 1);
        chk("rst_vblank", int'(vblank_a), 1);
        chk("rst_hsync_n", int'(hsync_n_a), 1);
        chk("rst_vsync_n", int'(vsync_n_a), 1);
        chk("rst_line_start", int'(line_start_a), 0);
        chk("rst_frame_start", int'(frame_start_a), 0);
      end
      2: begin
        chk("hsync_on_hcnt", int'(hcnt_a), 176);
        chk("hsync_on", int'(hsync_n_a), 0);
      end
      3: begin
        chk("hblank_off_hcnt", int'(hcnt_a), 272);
        chk("hblank_off", int'(hblank_a), 0);
      end
      4: begin
        chk("hmax_hcnt", int'(hcnt_a), 511);
        chk("hmax_h_load_n", int'(h_load_n_a), 0);
      end
      5: begin
        chk("wrap_hcnt", int'(hcnt_a), 128);
        chk("wrap_vcnt", int'(vcnt_a), 249);
        chk("wrap_line_start", int'(line_start_a), 1);
      end
      6: begin
        chk("freeze_hcnt", int'(hcnt_a), 300);
        chk("freeze_h_load_n", int'(h_load_n_a), 1);
      end
      7: chk("resume_hcnt", int'(hcnt_a), 301);
      8: begin
        chk("async_rst_hcnt", int'(hcnt_a), 128);
        chk("async_rst_vcnt", int'(vcnt_a), 248);
        chk("async_rst_hblank", int'(hblank_a), 1);
      end
      9: begin
        chk("b_fmax_hcnt", int'(hcnt_b), 511);
        chk("b_fmax_vcnt", int'(vcnt_b), 511);
        chk("b_fmax_v_load_n", int'(v_load_n_b), 0);
      end
      10: begin
        chk("b_fwrap_hcnt", int'(hcnt_b), 128);
        chk("b_fwrap_vcnt", int'(vcnt_b), 488);
        chk("b_fwrap_frame_start", int'(frame_start_b), 1);
        chk("b_fwrap_line_start", int'(line_start_b), 1);
        chk("b_sync_on_eq_off", int'(hsync_n_b), 1);
        chk("b_hblank_on_unreachable", int'(hblank_b), 0);
      end
      default: ;
    endcase
  end

  // ---------------- stimulus ----------------
  // Drive inputs for the coming posedge, then return just after the
  // following negedge (where that edge's results have been compared).
  task automatic tick(input logic pc, input logic rn, input int pn);
    pix_ce = pc;
    run    = rn;
    pin    = pn;
    @(negedge clk);
    #1;
  endtask

  initial begin
    int guard;
    clear_n = 1'b0;
    pix_ce  = 1'b1;
    run     = 1'b1;
    pin     = 1;
    @(negedge clk);
    #1;
    clear_n = 1'b1;

    // One line at full rate, with pinned points along the way.
    for (int n = 1; n <= 385; n++) begin
      tick(1'b1, 1'b1, (n == 48) ? 2 : (n == 144) ? 3 : (n == 383) ? 4 :
                       (n == 384) ? 5 : 0);
    end

    // pix_ce every fourth clk for two line periods.
    for (int i = 0; i < 3200; i++) tick((i % 4) == 0, 1'b1, 0);

    // Freeze at hcnt=300, then resume.
    guard = 0;
    while (m_h(PA, ma) != 300 && guard < 1000) begin
      tick(1'b1, 1'b1, 0);
      guard++;
    end
    for (int i = 0; i < 50; i++) tick(1'b1, 1'b0, 6);
    tick(1'b1, 1'b1, 7);

    // Asynchronous reset pulse between edges, with no advance on the next edge.
    #1;
    pix_ce  = 1'b1;
    run     = 1'b0;
    clear_n = 1'b0;
    #2;
    clear_n = 1'b1;
    pin     = 8;
    @(negedge clk);
    #1;

    // Full short frame on instance b (24 lines of 384).
    for (int n = 1; n <= 9217; n++) begin
      tick(1'b1, 1'b1, (n == 9215) ? 9 : (n == 9216) ? 10 : 0);
    end

    // Random enable patterns across more than a short frame.
    for (int i = 0; i < 24000; i++) begin
      tick(($urandom % 8) != 0, ($urandom % 16) != 0, 0);
    end

    tick(1'b0, 1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
